// File: rtl/if_id_pkg.sv
// Shared types and constants for the fetch/decode decoupling buffer.
package if_id_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD = 32'hffff_ffff;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fin_delay_counter.sv
// Counts halted-and-empty cycles and raises a sticky fin_sign after FIN_DELAY of them.
module fin_delay_counter #(
    parameter int FIN_DELAY = 7
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic fin_sign
);

    logic [3:0] cnt;

    // fin_sign is set on the same edge the count reaches FIN_DELAY; clear never drops it
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt      <= 4'd0;
            fin_sign <= 1'b0;
        end else if (clear) begin
            cnt <= 4'd0;
        end else if (enable) begin
            cnt <= cnt + 4'd1;
            if (cnt == 4'(FIN_DELAY - 1))
                fin_sign <= 1'b1;
        end
    end

endmodule

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue with halt-word detection and delayed finish flag.
// Optional zero-latency bypass when built with IF_ID_BYPASS_EN defined.
module if_id_queue
    import if_id_pkg::*;
#(
    parameter int DEPTH     = 2,
    parameter int FIN_DELAY = 7
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        in_valid,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_instr,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    input  logic        out_ready,
    input  logic        flush,
    output logic        halted,
    output logic        fin_sign
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;

    logic         buf_empty;
    logic         push;
    logic         is_halt;
    logic         bypass;
    logic         store;
    logic         pop;
    logic         halt_accept;
    fetch_entry_t head;

    always_comb begin
        buf_empty   = (count == '0);
        in_ready    = !halted && (count < DEPTH_CNT);
        push        = in_valid && in_ready;
        is_halt     = (in_instr == HALT_WORD);
        halt_accept = push && is_halt;
`ifdef IF_ID_BYPASS_EN
        bypass      = buf_empty && !flush && in_valid && !is_halt && in_ready;
`else
        bypass      = 1'b0;
`endif
        // A bypassed word consumed this cycle never enters storage
        store       = push && !is_halt && !(bypass && out_ready);
        pop         = !buf_empty && out_ready;
        head        = mem[rd_ptr];
    end

    always_comb begin
        out_valid = !buf_empty;
        out_pc    = buf_empty ? 32'h0 : head.pc;
        out_instr = buf_empty ? NOP_INSTR : head.instr;
`ifdef IF_ID_BYPASS_EN
        if (bypass) begin
            out_valid = 1'b1;
            out_pc    = in_pc;
            out_instr = in_instr;
        end
`endif
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET && !flush && store)
            mem[wr_ptr] <= '{pc: in_pc, instr: in_instr};
    end

    // Flush discards everything in flight, including a wrong-path halt word
    always_ff @(posedge CLOCK) begin
        if (RESET || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            halted <= 1'b0;
        end else begin
            if (store)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({store, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (halt_accept)
                halted <= 1'b1;
        end
    end

    fin_delay_counter #(
        .FIN_DELAY(FIN_DELAY)
    ) u_fin (
        .clock   (CLOCK),
        .reset   (RESET),
        .enable  (halted && buf_empty && !fin_sign),
        .clear   (flush),
        .fin_sign(fin_sign)
    );

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue with a queue-based reference model checked every cycle.
module tb_if_id_queue;
    import if_id_pkg::*;

    localparam int DEPTH     = 2;
    localparam int FIN_DELAY = 7;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_pc = 32'h0;
    logic [31:0] in_instr = 32'h0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready = 1'b0;
    logic        flush = 1'b0;
    logic        halted;
    logic        fin_sign;

    int checks = 0;
    int errors = 0;

    if_id_queue #(
        .DEPTH(DEPTH),
        .FIN_DELAY(FIN_DELAY)
    ) dut (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .in_valid (in_valid),
        .in_pc    (in_pc),
        .in_instr (in_instr),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_pc   (out_pc),
        .out_instr(out_instr),
        .out_ready(out_ready),
        .flush    (flush),
        .halted   (halted),
        .fin_sign (fin_sign)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                                  input logic ordy, input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = instr;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    // Reference model: an ordered list of held words plus halt/finish bookkeeping
    fetch_entry_t mq[$];
    bit m_halted = 1'b0;
    bit m_fin    = 1'b0;
    bit m_live   = 1'b0;
    int m_wait   = 0;

    function automatic bit m_bypass();
`ifdef IF_ID_BYPASS_EN
        return (mq.size() == 0) && !flush && in_valid && (in_instr != HALT_WORD) && !m_halted;
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge CLOCK) begin : model_update
        bit rdy;
        bit empty;
        bit byp;
        if (RESET) begin
            mq.delete();
            m_halted = 1'b0;
            m_fin    = 1'b0;
            m_wait   = 0;
            m_live   = 1'b1;
        end else if (flush) begin
            mq.delete();
            m_halted = 1'b0;
            m_wait   = 0;
        end else begin
            rdy   = !m_halted && (mq.size() < DEPTH);
            empty = (mq.size() == 0);
            byp   = m_bypass();
            if (m_halted && empty && !m_fin) begin
                m_wait++;
                if (m_wait == FIN_DELAY)
                    m_fin = 1'b1;
            end
            if (!empty && out_ready)
                void'(mq.pop_front());
            if (in_valid && rdy) begin
                if (in_instr == HALT_WORD)
                    m_halted = 1'b1;
                else if (!(byp && out_ready))
                    mq.push_back('{pc: in_pc, instr: in_instr});
            end
        end
    end

    always @(negedge CLOCK) begin : compare
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einstr;
        if (m_live) begin
            if (m_bypass()) begin
                ev = 1'b1; epc = in_pc; einstr = in_instr;
            end else if (mq.size() != 0) begin
                ev = 1'b1; epc = mq[0].pc; einstr = mq[0].instr;
            end else begin
                ev = 1'b0; epc = 32'h0; einstr = NOP_INSTR;
            end
            check_output("cyc_out_valid", {31'b0, out_valid}, {31'b0, ev});
            check_output("cyc_out_pc", out_pc, epc);
            check_output("cyc_out_instr", out_instr, einstr);
            check_output("cyc_in_ready", {31'b0, in_ready},
                         {31'b0, (!m_halted && (mq.size() < DEPTH))});
            check_output("cyc_halted", {31'b0, halted}, {31'b0, m_halted});
            check_output("cyc_fin_sign", {31'b0, fin_sign}, {31'b0, m_fin});
        end
    end

    task automatic check_reset_values(input string tag);
        check_output({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
        check_output({tag, "_out_pc"}, out_pc, 32'h0);
        check_output({tag, "_out_instr"}, out_instr, 32'h0);
        check_output({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        check_output({tag, "_halted"}, {31'b0, halted}, 32'd0);
        check_output({tag, "_fin_sign"}, {31'b0, fin_sign}, 32'd0);
    endtask

    initial begin
        RESET = 1'b1;
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        tick();
        check_reset_values("rst");
        RESET = 1'b0;

        // Single word through with one cycle latency
        apply_stimulus(1'b1, 32'h0, 32'h2008_0005, 1'b1, 1'b0);
        tick();
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check_output("t1_valid", {31'b0, out_valid}, 32'd1);
        check_output("t1_pc", out_pc, 32'h0);
        check_output("t1_instr", out_instr, 32'h2008_0005);
        tick();
        check_output("t1_drain_valid", {31'b0, out_valid}, 32'd0);
        check_output("t1_drain_instr", out_instr, 32'h0);

        // Fill to DEPTH, hold off a third word, then drain in order
        apply_stimulus(1'b1, 32'h0, 32'h0000_0011, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b1, 32'h4, 32'h0000_0022, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b1, 32'h8, 32'h0000_0033, 1'b0, 1'b0);
        check_output("t2_full_ready", {31'b0, in_ready}, 32'd0);
        tick();
        check_output("t2_head0", out_pc, 32'h0);
        check_output("t2_still_full", {31'b0, in_ready}, 32'd0);
        out_ready = 1'b1;
        tick();
        check_output("t2_head4", out_pc, 32'h4);
        check_output("t2_slot_free", {31'b0, in_ready}, 32'd1);
        tick();
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check_output("t2_head8", out_pc, 32'h8);
        check_output("t2_instr8", out_instr, 32'h0000_0033);
        tick();
        check_output("t2_empty", {31'b0, out_valid}, 32'd0);

        // Flush with two entries held and a concurrent offered word
        apply_stimulus(1'b1, 32'h10, 32'h0000_0010, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b1, 32'h14, 32'h0000_0014, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b1, 32'h40, 32'h0000_0044, 1'b0, 1'b1);
        tick();
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check_output("t3_flush_valid", {31'b0, out_valid}, 32'd0);
        check_output("t3_flush_ready", {31'b0, in_ready}, 32'd1);
        tick();
        check_output("t3_not_stored", {31'b0, out_valid}, 32'd0);

        // Halt word while one entry drains; finish follows FIN_DELAY cycles later
        apply_stimulus(1'b1, 32'h50, 32'h0000_0055, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b1, 32'h54, HALT_WORD, 1'b1, 1'b0);
        tick();
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check_output("t4_halted", {31'b0, halted}, 32'd1);
        check_output("t4_ready_low", {31'b0, in_ready}, 32'd0);
        check_output("t4_empty", {31'b0, out_valid}, 32'd0);
        for (int i = 1; i < 7; i++) begin
            tick();
            check_output("t4_fin_early", {31'b0, fin_sign}, 32'd0);
        end
        tick();
        check_output("t4_fin_rise", {31'b0, fin_sign}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_output("t4_fin_sticky", {31'b0, fin_sign}, 32'd1);
        check_output("t4_halt_cleared", {31'b0, halted}, 32'd0);

        // Wrong-path halt cancelled by a flush two cycles later
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        apply_stimulus(1'b1, 32'h80, HALT_WORD, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check_output("t5_halted", {31'b0, halted}, 32'd1);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_output("t5_unhalted", {31'b0, halted}, 32'd0);
        check_output("t5_ready", {31'b0, in_ready}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_output("t5_no_fin", {31'b0, fin_sign}, 32'd0);
        end
        apply_stimulus(1'b1, 32'h60, 32'h0000_0066, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check_output("t5_held_pc", out_pc, 32'h60);
        RESET = 1'b1;
        tick();
        check_reset_values("t5_rst");
        RESET = 1'b0;
        tick();

`ifdef IF_ID_BYPASS_EN
        apply_stimulus(1'b1, 32'h70, 32'h3c01_0001, 1'b1, 1'b0);
        #1;
        check_output("t6_byp_valid", {31'b0, out_valid}, 32'd1);
        check_output("t6_byp_instr", out_instr, 32'h3c01_0001);
        tick();
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check_output("t6_not_stored", {31'b0, out_valid}, 32'd0);
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Decoupling buffer between instruction fetch and decode. It accepts fetched {PC, instruction} pairs from the fetch stage, holds up to DEPTH of them in order, and presents the oldest to decode through a valid/ready handshake. The fetch stage's PC stall comes from backpressure (`in_ready`), and a taken branch or jump empties the buffer through `flush`. The block also detects the 32'hffffffff end-of-program word and raises `fin_sign` once the pipeline has drained.

## Interface
Parameters:
- `DEPTH`, 2: number of entries; a power of two, at least 2.
- `FIN_DELAY`, 7: cycles between halted-and-empty and `fin_sign` rising; 1 to 15.

Ports:
- `CLOCK`  in  1  the single clock; all state updates on the rising edge.
- `RESET`  in  1  synchronous, active-high reset, sampled on the rising edge of `CLOCK`.
- `in_valid`  in  1  the fetch stage presents a word.
- `in_pc`  in  32  PC of the presented word.
- `in_instr`  in  32  the presented instruction word.
- `in_ready`  out  1  the buffer will accept the word this cycle; drives the PC stall (stall = !`in_ready`).
- `out_valid`  out  1  the head entry is valid.
- `out_pc`  out  32  PC of the head entry.
- `out_instr`  out  32  instruction of the head entry; NOP (32'h0) when `out_valid`=0.
- `out_ready`  in  1  decode consumes the head this cycle; low means decode is stalled.
- `flush`  in  1  a branch or jump resolved taken; discard all buffered words.
- `halted`  out  1  the end-of-program word has been accepted.
- `fin_sign`  out  1  program finished; sticky until reset.

## Operation
- Storage: circular buffer with `rd_ptr`, `wr_ptr` ((log2 DEPTH) bits, wrap modulo DEPTH) and `count` ((log2 DEPTH)+1 bits).
- Push: `in_valid` & `in_ready`. Pop: `out_valid` & `out_ready`.
- `in_ready` = !`halted` & (`count` < DEPTH). It does not depend on `out_ready`, so there is no combinational path from the output side to the input side.
- A simultaneous push and pop leaves `count` unchanged and advances both pointers.
- Halt word: a push whose `in_instr` = 32'hffffffff is not stored. Instead it sets `halted`, and `in_ready` stays 0 from then on.
- Finish counter, 4 bits:
  - It counts while `halted` & `count`==0 & !`fin_sign`.
  - When it reaches FIN_DELAY, `fin_sign` is set and stays set until reset.
- Flush has priority over everything else in its cycle. It:
  - clears `count` and both pointers;
  - drops any push or pop in the same cycle;
  - clears `halted` and the finish counter, because the halt word was fetched down a wrong path.
  - Flush does not clear `fin_sign` once it is set.
- `RESET` has priority over `flush`.
  - Reset values: `count`=0, pointers=0, `out_valid`=0, `out_pc`=0, `out_instr`=0, `in_ready`=1, `halted`=0, `fin_sign`=0, finish counter=0.
  - Entry contents are not reset.
  - A reset asserted mid-operation discards all buffered entries in that same edge.

## Timing
- Default latency: a word pushed at edge k appears on `out_*` in the cycle after edge k, provided it is the oldest entry.
- Outputs are a function of registered state only: the head entry plus `count`.
- Full (`count`=DEPTH): `in_ready`=0 during that cycle, even if a pop is happening at the same time. The buffer frees a slot one cycle after the pop.
- Empty: `out_valid`=0 and `out_instr`=NOP, so decode sees a bubble.
- Halt timing: the halt word is accepted at edge k. `halted` is 1 in the cycle after edge k. If the buffer is empty, `fin_sign` is 1 FIN_DELAY cycles after `halted` rises.
- A flush at edge k gives `out_valid`=0 in the cycle after edge k. A push accepted in that next cycle is visible the cycle after it.

## Configuration
- `IF_ID_BYPASS_EN`, when defined:
  - If the buffer is empty, there is no flush, `in_valid`=1 and `in_instr` is not the halt word, the input drives `out_*` combinationally with `out_valid`=1.
  - If `out_ready`=1 in that cycle, the word is consumed and never stored. Latency is 0.
  - The halt word is never bypassed.
- When not defined: no combinational path from input to output; latency is always at least 1 cycle.

## Structure
- Shared package `if_id_pkg`:
  - `NOP_INSTR` = 32'h0
  - `HALT_WORD` = 32'hffffffff
  - `fetch_entry_t` struct {pc[31:0], instr[31:0]}
- One sub-module, `fin_delay_counter`, takes enable and clear inputs and the FIN_DELAY parameter, and produces the sticky `fin_sign`.
- The buffer storage and pointers stay inline.

## Test plan
- Reset, then push PC 0x0/instr 0x20080005 with `out_ready`=1 → the next cycle shows `out_valid`=1, `out_pc`=0x0, `out_instr`=0x20080005; after the pop, `out_valid`=0 and `out_instr`=0.
- With `out_ready`=0, push PCs 0x0, 0x4, then offer 0x8 → `in_ready`=0 once 2 entries are held and 0x8 is held off. Raise `out_ready` → pops in order 0x0, 0x4, and 0x8 is accepted one cycle after the first pop.
- With 2 entries held, assert `flush` together with `in_valid` (PC 0x40) → the next cycle has `out_valid`=0 and `count`=0, and 0x40 is not stored.
- Push 0xffffffff while 1 entry is held, with `out_ready`=1 → `halted`=1 and `in_ready`=0. `fin_sign` rises exactly 7 cycles after the buffer becomes empty and stays 1 across a later flush.
- Push 0xffffffff, then `flush` 2 cycles later → `halted`=0, `in_ready`=1, and `fin_sign` never rises. Assert `RESET` with 1 entry held → all outputs return to their reset values at the next edge.
- With `IF_ID_BYPASS_EN` defined and the buffer empty: push 0x3c010001 with `out_ready`=1 → `out_valid`=1 in the same cycle and `count` stays 0.
